// File: rtl/pow2_mod_engine.sv
// pow2_mod_engine: sequential 2^n mod MOD for one RNS channel.
// Left-to-right binary exponentiation with a bit-serial modular squarer.
module pow2_mod_engine #(
   parameter  int MOD = 7,
   parameter  int N_W = 32,
   localparam int R_W = $clog2(MOD)
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           in_valid,
   output logic           in_ready,
   input  logic [N_W-1:0] n,
   output logic           out_valid,
   input  logic           out_ready,
   output logic [R_W-1:0] res,
   output logic           busy
);

   localparam int I_W = $clog2(N_W) + 1;
   localparam int M_W = $clog2(R_W);
   localparam logic [R_W:0] MODV = (R_W+1)'(MOD);

   typedef enum logic [1:0] {
      IDLE,
      SQUARE,
      DOUBLE,
      DONE
   } state_t;

   state_t         state_q;
   logic [N_W-1:0] n_q;
   logic [I_W-1:0] idx_q;
   logic [R_W-1:0] r_q;
   logic [R_W-1:0] acc_q;
   logic [M_W-1:0] mcnt_q;
   logic [R_W-1:0] res_q;

   logic [R_W:0]   t1, t2, d1;
   logic [R_W-1:0] acc_d;
   logic [R_W-1:0] r_d;
   logic           n_bit;

   // Operands stay below MOD, so one conditional subtract per add suffices.
   always_comb begin
      n_bit = |(n_q & (N_W'(1) << idx_q));
      t1 = {acc_q, 1'b0};
      if (t1 >= MODV) t1 = t1 - MODV;
      t2 = t1 + (r_q[mcnt_q] ? {1'b0, r_q} : '0);
      if (t2 >= MODV) t2 = t2 - MODV;
      acc_d = t2[R_W-1:0];
      d1 = {acc_q, 1'b0};
      if (d1 >= MODV) d1 = d1 - MODV;
      r_d = n_bit ? d1[R_W-1:0] : acc_q;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         n_q     <= '0;
         idx_q   <= '0;
         r_q     <= '0;
         acc_q   <= '0;
         mcnt_q  <= '0;
         res_q   <= '0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (in_valid) begin
                  n_q     <= n;
                  r_q     <= R_W'(1);
                  acc_q   <= '0;
                  idx_q   <= I_W'(N_W - 1);
                  mcnt_q  <= M_W'(R_W - 1);
                  state_q <= SQUARE;
               end
            end
            SQUARE: begin
               acc_q <= acc_d;
               if (mcnt_q == '0) state_q <= DOUBLE;
               else              mcnt_q  <= mcnt_q - M_W'(1);
            end
            DOUBLE: begin
               r_q    <= r_d;
               acc_q  <= '0;
               mcnt_q <= M_W'(R_W - 1);
               if (idx_q == '0) begin
                  res_q   <= r_d;
                  state_q <= DONE;
               end else begin
                  idx_q   <= idx_q - I_W'(1);
                  state_q <= SQUARE;
               end
            end
            DONE: begin
               if (out_ready) state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == DONE);
   assign busy      = (state_q == SQUARE) || (state_q == DOUBLE);
   assign res       = res_q;

endmodule
